// File: rtl/write_ram_mem.sv
// Writes a snapshot of a parallel word array into an external RAM, one word per
// two cycles, then optionally reads every word back and flags the first mismatch.
module write_ram_mem #(
  parameter int DEP    = 32,
  parameter int WID    = 8,
  parameter int VERIFY = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [DEP*WID-1:0] wr_data_in,
  input  logic [WID-1:0]     ram_q_data_in,
  output logic [8:0]         address,
  output logic [WID-1:0]     ram_data_out,
  output logic               wren,
  output logic               busy,
  output logic               done,
  output logic               mismatch,
  output logic [8:0]         fail_index
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_INC, S_RADDR, S_RWAIT, S_CMP, S_DONE
  } state_t;

  localparam int          IW   = (DEP > 1) ? $clog2(DEP) : 1;
  localparam logic [8:0]  LAST = 9'(DEP - 1);

  state_t         r_state, w_state_next;
  logic [8:0]     r_index, w_index_next;
  logic           r_done, w_done_next;
  logic           r_mismatch, w_mismatch_next;
  logic [8:0]     r_fail_index, w_fail_index_next;
  logic           w_accept;
  logic [WID-1:0] w_words [DEP];
  logic [WID-1:0] r_snap  [DEP];
  logic [WID-1:0] w_snap_word;

  genvar gi;
  generate
    for (gi = 0; gi < DEP; gi++) begin : g_unpack
      assign w_words[gi] = wr_data_in[gi*WID +: WID];
    end
  endgenerate

  assign w_accept    = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
  assign w_snap_word = r_snap[r_index[IW-1:0]];

  // Snapshot is deliberately outside the reset domain: its contents only matter after a start.
  always_ff @(posedge clk) begin
    if (w_accept) r_snap <= w_words;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_index      <= '0;
      r_done       <= 1'b0;
      r_mismatch   <= 1'b0;
      r_fail_index <= '0;
    end else begin
      r_state      <= w_state_next;
      r_index      <= w_index_next;
      r_done       <= w_done_next;
      r_mismatch   <= w_mismatch_next;
      r_fail_index <= w_fail_index_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_index_next      = r_index;
    w_done_next       = r_done;
    w_mismatch_next   = r_mismatch;
    w_fail_index_next = r_fail_index;
    address           = '0;
    ram_data_out      = '0;
    wren              = 1'b0;
    busy              = 1'b1;
    case (r_state)
      S_IDLE, S_DONE: begin
        busy = 1'b0;
        if (start) begin
          w_state_next      = S_WRITE;
          w_index_next      = '0;
          w_done_next       = 1'b0;
          w_mismatch_next   = 1'b0;
          w_fail_index_next = '0;
        end
      end
      S_WRITE: begin
        address      = r_index;
        ram_data_out = w_snap_word;
        wren         = 1'b1;
        w_state_next = S_INC;
      end
      S_INC: begin
        address = r_index;
        if (r_index < LAST) begin
          w_index_next = r_index + 9'd1;
          w_state_next = S_WRITE;
        end else begin
          w_index_next = '0;
          if (VERIFY != 0) begin
            w_state_next = S_RADDR;
          end else begin
            w_state_next = S_DONE;
            w_done_next  = 1'b1;
          end
        end
      end
      S_RADDR: begin
        address      = r_index;
        w_state_next = S_RWAIT;
      end
      S_RWAIT: begin
        address      = r_index;
        w_state_next = S_CMP;
      end
      S_CMP: begin
        address = r_index;
        // Only the first differing word records its index.
        if ((ram_q_data_in != w_snap_word) && !r_mismatch) begin
          w_mismatch_next   = 1'b1;
          w_fail_index_next = r_index;
        end
        if (r_index < LAST) begin
          w_index_next = r_index + 9'd1;
          w_state_next = S_RADDR;
        end else begin
          w_state_next = S_DONE;
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign done       = r_done;
  assign mismatch   = r_mismatch;
  assign fail_index = r_fail_index;

endmodule

// File: tb/tb_write_ram_mem.sv
// Drives two instances (write-only and write+verify) against behavioural RAM models
// and checks write sequences, read-back verdicts, latency, reset and restart behaviour.
module tb_write_ram_mem;

  localparam int DEP = 32;
  localparam int WID = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start0 = 1'b0, start1 = 1'b0;
  logic [DEP*WID-1:0] wr_data = '0;
  logic [WID-1:0]     q0, q1;
  logic [8:0]         address0, address1, fail_index0, fail_index1;
  logic [WID-1:0]     data0, data1;
  logic               wren0, wren1, busy0, busy1, done0, done1, mismatch0, mismatch1;

  int tests_run = 0;
  int tests_failed = 0;

  logic [WID-1:0] mem0 [512];
  logic [WID-1:0] mem1 [512];
  bit             corrupt [512];
  logic [16:0]    log0 [$];
  logic [16:0]    log1 [$];
  logic [WID-1:0] exp_w [DEP];

  always #5 clk = ~clk;

  write_ram_mem #(.DEP(DEP), .WID(WID), .VERIFY(0)) u_dut0 (
    .clk(clk), .reset(rst_n), .start(start0), .wr_data_in(wr_data), .ram_q_data_in(q0),
    .address(address0), .ram_data_out(data0), .wren(wren0), .busy(busy0), .done(done0),
    .mismatch(mismatch0), .fail_index(fail_index0)
  );

  write_ram_mem #(.DEP(DEP), .WID(WID), .VERIFY(1)) u_dut1 (
    .clk(clk), .reset(rst_n), .start(start1), .wr_data_in(wr_data), .ram_q_data_in(q1),
    .address(address1), .ram_data_out(data1), .wren(wren1), .busy(busy1), .done(done1),
    .mismatch(mismatch1), .fail_index(fail_index1)
  );

  // RAM models: synchronous write, registered read; dut1's read path can corrupt chosen addresses.
  always @(posedge clk) begin
    if (wren0) begin
      mem0[address0] <= data0;
      log0.push_back({address0, data0});
    end
    q0 <= mem0[address0];
    if (wren1) begin
      mem1[address1] <= data1;
      log1.push_back({address1, data1});
    end
    q1 <= mem1[address1] ^ (corrupt[address1] ? 8'hA5 : 8'h00);
  end

  function automatic logic [DEP*WID-1:0] rand_words();
    logic [DEP*WID-1:0] r;
    for (int i = 0; i < DEP; i++) r[i*WID +: WID] = WID'($urandom);
    return r;
  endfunction

  task automatic load_data(input logic [DEP*WID-1:0] v);
    wr_data = v;
    for (int i = 0; i < DEP; i++) exp_w[i] = v[i*WID +: WID];
  endtask

  // Starts one instance, returns edges from accepting edge until done observed.
  task automatic launch(input int which, input bit scramble, output int cycles);
    log0.delete();
    log1.delete();
    @(negedge clk);
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
    cycles = 0;
    while (cycles < 400) begin
      if (scramble) wr_data = rand_words();
      @(posedge clk); #1;
      cycles++;
      if ((which == 0) ? done0 : done1) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (wren0 !== 1'b0 || wren1 !== 1'b0) begin tests_failed++; $display("FAIL reset_wren got %b/%b need 0/0", wren0, wren1); end
    tests_run++; if (busy0 !== 1'b0 || busy1 !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b/%b need 0/0", busy0, busy1); end
    tests_run++; if (done0 !== 1'b0 || done1 !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b/%b need 0/0", done0, done1); end
    tests_run++; if (mismatch0 !== 1'b0 || mismatch1 !== 1'b0) begin tests_failed++; $display("FAIL reset_mismatch got %b/%b need 0/0", mismatch0, mismatch1); end
    tests_run++; if (address0 !== 9'd0 || address1 !== 9'd0) begin tests_failed++; $display("FAIL reset_address got %0d/%0d need 0/0", address0, address1); end
    tests_run++; if (fail_index0 !== 9'd0 || fail_index1 !== 9'd0) begin tests_failed++; $display("FAIL reset_fail_index got %0d/%0d need 0/0", fail_index0, fail_index1); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (busy0 !== 1'b0 || busy1 !== 1'b0) begin tests_failed++; $display("FAIL idle_after_reset busy got %b/%b need 0/0", busy0, busy1); end
    $display("[TB] reset: outputs checked in and after reset");
  endtask

  task automatic test_write_only(input bit randomized);
    logic [DEP*WID-1:0] v;
    int cyc, errs;
    for (int i = 0; i < DEP; i++) v[i*WID +: WID] = randomized ? WID'($urandom) : WID'(i + 8'h40);
    load_data(v);
    launch(0, 1'b0, cyc);
    tests_run++; if (cyc !== 2*DEP) begin tests_failed++; $display("FAIL wo_latency got %0d need %0d", cyc, 2*DEP); end
    tests_run++; if (log0.size() !== DEP) begin tests_failed++; $display("FAIL wo_pulses got %0d need %0d", log0.size(), DEP); end
    errs = 0;
    for (int i = 0; i < DEP && i < log0.size(); i++)
      if (log0[i] !== {9'(i), exp_w[i]}) begin
        errs++;
        $display("FAIL wo_write[%0d] got addr %0d data %h need addr %0d data %h", i, log0[i][16:8], log0[i][7:0], i, exp_w[i]);
      end
    tests_run++; if (errs != 0) tests_failed++;
    @(posedge clk); #1;
    tests_run++; if (busy0 !== 1'b0 || done0 !== 1'b1) begin tests_failed++; $display("FAIL wo_final busy/done got %b/%b need 0/1", busy0, done0); end
    tests_run++; if (address0 !== 9'd0 || data0 !== 8'd0 || wren0 !== 1'b0) begin tests_failed++; $display("FAIL wo_done_outputs got addr %0d data %h wren %b need 0 00 0", address0, data0, wren0); end
    $display("[TB] write-only run (random=%0d): latency %0d, %0d pulses", randomized, cyc, log0.size());
  endtask

  task automatic test_verify(input int n_corrupt, input bit fixed59);
    int cyc, errs, exp_fail;
    bit exp_mis;
    for (int i = 0; i < 512; i++) corrupt[i] = 1'b0;
    if (fixed59) begin
      corrupt[5] = 1'b1;
      corrupt[9] = 1'b1;
    end
    for (int k = 0; k < n_corrupt; k++) corrupt[$urandom_range(DEP-1, 0)] = 1'b1;
    exp_mis = 1'b0;
    exp_fail = 0;
    for (int i = DEP-1; i >= 0; i--) if (corrupt[i]) begin exp_mis = 1'b1; exp_fail = i; end
    load_data(rand_words());
    launch(1, 1'b0, cyc);
    tests_run++; if (cyc !== 5*DEP) begin tests_failed++; $display("FAIL vf_latency got %0d need %0d", cyc, 5*DEP); end
    tests_run++; if (mismatch1 !== exp_mis) begin tests_failed++; $display("FAIL vf_mismatch got %b need %b", mismatch1, exp_mis); end
    tests_run++; if (fail_index1 !== 9'(exp_fail)) begin tests_failed++; $display("FAIL vf_fail_index got %0d need %0d", fail_index1, exp_fail); end
    errs = 0;
    for (int i = 0; i < DEP; i++) if (mem1[i] !== exp_w[i]) errs++;
    tests_run++; if (errs != 0 || log1.size() !== DEP) begin tests_failed++; $display("FAIL vf_ram_contents got %0d bad words, %0d pulses need 0, %0d", errs, log1.size(), DEP); end
    for (int i = 0; i < 512; i++) corrupt[i] = 1'b0;
    $display("[TB] verify run: latency %0d mismatch %b fail_index %0d", cyc, mismatch1, fail_index1);
  endtask

  task automatic test_snapshot();
    int cyc, errs;
    load_data(rand_words());
    launch(1, 1'b1, cyc);
    errs = 0;
    for (int i = 0; i < DEP; i++) if (mem1[i] !== exp_w[i]) errs++;
    tests_run++; if (errs != 0) begin tests_failed++; $display("FAIL snapshot_ram got %0d words changed need 0", errs); end
    tests_run++; if (mismatch1 !== 1'b0 || cyc !== 5*DEP) begin tests_failed++; $display("FAIL snapshot_run mismatch %b latency %0d need 0 %0d", mismatch1, cyc, 5*DEP); end
    $display("[TB] snapshot: input scrambled every cycle, %0d RAM words differ", errs);
  endtask

  task automatic test_reset_midrun();
    int n, cyc, errs;
    bit found;
    load_data(rand_words());
    log0.delete();
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    found = 1'b0;
    for (n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (wren0 && address0 == 9'd10) begin found = 1'b1; break; end
    end
    tests_run++; if (!found) begin tests_failed++; $display("FAIL midrun_reach_index10 got timeout need wren at addr 10"); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (wren0 !== 1'b0 || address0 !== 9'd0 || busy0 !== 1'b0) begin tests_failed++; $display("FAIL midrun_async wren/addr/busy got %b/%0d/%b need 0/0/0", wren0, address0, busy0); end
    tests_run++; if (log0.size() !== 10) begin tests_failed++; $display("FAIL midrun_pulses_before got %0d need 10", log0.size()); end
    repeat (5) @(posedge clk);
    #1;
    tests_run++; if (log0.size() !== 10) begin tests_failed++; $display("FAIL midrun_no_pulse_in_reset got %0d need 10", log0.size()); end
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    tests_run++; if (busy0 !== 1'b0 || wren0 !== 1'b0 || done0 !== 1'b0) begin tests_failed++; $display("FAIL midrun_wait_idle busy/wren/done got %b/%b/%b need 0/0/0", busy0, wren0, done0); end
    load_data(rand_words());
    launch(0, 1'b0, cyc);
    errs = 0;
    for (int i = 0; i < DEP && i < log0.size(); i++) if (log0[i] !== {9'(i), exp_w[i]}) errs++;
    tests_run++; if (errs != 0 || log0.size() !== DEP || cyc !== 2*DEP) begin tests_failed++; $display("FAIL midrun_rerun got %0d bad, %0d pulses, latency %0d need 0, %0d, %0d", errs, log0.size(), cyc, DEP, 2*DEP); end
    $display("[TB] reset mid-run at index 10, rerun latency %0d", cyc);
  endtask

  task automatic test_back_to_back();
    int n, hi;
    corrupt[3] = 1'b1;
    load_data(rand_words());
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1;
    for (n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      if (done1) break;
    end
    tests_run++; if (n + 1 !== 5*DEP) begin tests_failed++; $display("FAIL b2b_first_latency got %0d need %0d", n + 1, 5*DEP); end
    tests_run++; if (mismatch1 !== 1'b1 || fail_index1 !== 9'd3) begin tests_failed++; $display("FAIL b2b_first_verdict got %b/%0d need 1/3", mismatch1, fail_index1); end
    corrupt[3] = 1'b0;
    @(posedge clk); #1;
    tests_run++; if (done1 !== 1'b0 || mismatch1 !== 1'b0 || fail_index1 !== 9'd0 || busy1 !== 1'b1) begin tests_failed++; $display("FAIL b2b_restart done/mis/fail/busy got %b/%b/%0d/%b need 0/0/0/1", done1, mismatch1, fail_index1, busy1); end
    hi = 0;
    for (n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      if (busy1 === 1'b0) hi++;
      if (done1) break;
    end
    start1 = 1'b0;
    tests_run++; if (n + 1 !== 5*DEP) begin tests_failed++; $display("FAIL b2b_second_latency got %0d need %0d", n + 1, 5*DEP); end
    tests_run++; if (mismatch1 !== 1'b0 || hi !== 1) begin tests_failed++; $display("FAIL b2b_second_verdict mismatch %b idle-samples %0d need 0 1", mismatch1, hi); end
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (done1 !== 1'b1 || busy1 !== 1'b0) begin tests_failed++; $display("FAIL b2b_hold_done done/busy got %b/%b need 1/0", done1, busy1); end
    $display("[TB] back-to-back runs with start held high");
  endtask

  initial begin
    for (int i = 0; i < 512; i++) corrupt[i] = 1'b0;
    test_reset();
    test_write_only(1'b0);
    test_write_only(1'b1);
    test_verify(0, 1'b0);
    test_verify(0, 1'b1);
    test_verify(2, 1'b0);
    test_snapshot();
    test_reset_midrun();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
